// File: rtl/control_m.sv
// M-stage control register and data-cache access sequencer.
// Owns the pipeline-wide freeze, captures load data and counts stall cycles.
module control_m #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        M_in_op,
   input  logic [2:0]        M_in_f3,
   input  logic [4:0]        M_in_rd,
   input  logic              dc_ack,
   input  logic [DATA_W-1:0] dc_rdata,
   output logic [4:0]        M_out_op,
   output logic [2:0]        M_out_f3,
   output logic [4:0]        M_out_rd,
   output logic              dc_req,
   output logic              dc_we,
   output logic [1:0]        dc_size,
   output logic              dc_unsigned,
   output logic              waiting,
   output logic [DATA_W-1:0] ld_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [4:0] OpStore = 5'b01000;
   localparam logic [4:0] OpLoad  = 5'b00000;

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e state_q, state_d;
   logic   mem_op;

   // op=0 with rd=0 is a bubble; loads to x0 are dropped entirely.
   assign mem_op = (M_out_op == OpStore) | ((M_out_op == OpLoad) && (M_out_rd != 5'd0));

   assign dc_req      = mem_op & (state_q != StDone);
   assign waiting     = dc_req;
   assign dc_we       = (M_out_op == OpStore);
   assign dc_size     = M_out_f3[1:0];
   assign dc_unsigned = M_out_f3[2];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (mem_op && dc_ack) begin
               state_d = StDone;
            end else if (mem_op) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (dc_ack) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         M_out_op <= 5'd0;
         M_out_f3 <= 3'd0;
         M_out_rd <= 5'd0;
      end else if (!waiting) begin
         M_out_op <= M_in_op;
         M_out_f3 <= M_in_f3;
         M_out_rd <= M_in_rd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_data <= '0;
      end else if (dc_ack && dc_req && !dc_we) begin
         ld_data <= dc_rdata;
      end
   end

   // Saturating: holds at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (waiting && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
